// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: multi-channel RGB LED PWM driver with SOLID, BLINK, BREATHE
// and OFF modes. Settings are double-buffered and swap in only at the PWM
// period boundary so a period is never cut short or stretched.
module rgb_led_pwm #(
  parameter int NCH     = 2,
  parameter int PWM_W   = 8,
  parameter int BLINK_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [3*NCH-1:0]       color,
  input  logic [PWM_W*NCH-1:0]   level,
  input  logic [2*NCH-1:0]       mode,
  output logic [3*NCH-1:0]       rgb_led,
  output logic                   period_start
);

  localparam logic [1:0] MODE_SOLID   = 2'b00;
  localparam logic [1:0] MODE_BLINK   = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_OFF     = 2'b11;

  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic [PWM_W-1:0]       cnt;
  logic                   wrap;
  logic [BLINK_W-1:0]     blink_cnt;
  logic                   blink_phase;

  logic [3*NCH-1:0]       color_pend, color_act, color_nxt;
  logic [PWM_W*NCH-1:0]   level_pend, level_act, level_nxt;
  logic [2*NCH-1:0]       mode_pend,  mode_act,  mode_nxt;

  logic [PWM_W-1:0]       ramp [NCH];
  logic [NCH-1:0]         ramp_up;
  logic [PWM_W-1:0]       eff_level [NCH];

  // Next breathe ramp value and direction, returned as {up, ramp}.
  // Overshoot after a level decrease clamps to the level and turns down;
  // a zero level parks the ramp at zero heading up.
  function automatic logic [PWM_W:0] ramp_step(input logic [PWM_W-1:0] r,
                                               input logic             up,
                                               input logic [PWM_W-1:0] lvl);
    logic [PWM_W-1:0] nr;
    nr = '0;
    if (lvl == '0)
      return {1'b1, {PWM_W{1'b0}}};
    if (r > lvl)
      return {1'b0, lvl};
    if ((up && (r < lvl)) || (r == '0)) begin
      nr = r + 1'b1;
      return {nr != lvl, nr};
    end
    nr = r - 1'b1;
    return {nr == '0, nr};
  endfunction

  // Level all-ones means permanently on rather than 2^W-1 of 2^W cycles.
  function automatic logic is_lit(input logic [PWM_W-1:0] c,
                                  input logic [PWM_W-1:0] eff);
    return (c < eff) || (eff == CNT_MAX);
  endfunction

  assign wrap = (cnt == CNT_MAX);

  // A load in the wrap cycle itself must reach the next period, so the
  // active registers copy from the value pending will hold after this edge.
  assign color_nxt = load ? color : color_pend;
  assign level_nxt = load ? level : level_pend;
  assign mode_nxt  = load ? mode  : mode_pend;

  // Free-running period counter and global blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (wrap) begin
        blink_cnt <= blink_cnt + 1'b1;
        if (blink_cnt == '1)
          blink_phase <= ~blink_phase;
      end
    end
  end

  // Pending settings: last load before the wrap wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_pend <= '0;
      level_pend <= '0;
      mode_pend  <= {NCH{MODE_OFF}};
    end else if (load) begin
      color_pend <= color;
      level_pend <= level;
      mode_pend  <= mode;
    end
  end

  // Active settings change only at the period boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_act <= '0;
      level_act <= '0;
      mode_act  <= {NCH{MODE_OFF}};
    end else if (wrap) begin
      color_act <= color_nxt;
      level_act <= level_nxt;
      mode_act  <= mode_nxt;
    end
  end

  // Breathe ramps step once per period; entering BREATHE restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++)
        ramp[c] <= '0;
      ramp_up <= '1;
    end else if (wrap) begin
      for (int c = 0; c < NCH; c++) begin
        if (mode_nxt[2*c +: 2] == MODE_BREATHE) begin
          if (mode_act[2*c +: 2] != MODE_BREATHE) begin
            ramp[c]    <= '0;
            ramp_up[c] <= 1'b1;
          end else begin
            {ramp_up[c], ramp[c]} <= ramp_step(ramp[c], ramp_up[c],
                                               level_nxt[PWM_W*c +: PWM_W]);
          end
        end
      end
    end
  end

  // Per-channel effective duty level selected by mode.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      eff_level[c] = '0;
      case (mode_act[2*c +: 2])
        MODE_SOLID:   eff_level[c] = level_act[PWM_W*c +: PWM_W];
        MODE_BLINK:   eff_level[c] = blink_phase ? level_act[PWM_W*c +: PWM_W] : '0;
        MODE_BREATHE: eff_level[c] = ramp[c];
        default:      eff_level[c] = '0;
      endcase
    end
  end

  // Output stage: one-cycle registered LED drive and period marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_led      <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= (cnt == '0);
      for (int c = 0; c < NCH; c++)
        rgb_led[3*c +: 3] <= color_act[3*c +: 3] & {3{is_lit(cnt, eff_level[c])}};
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb_rgb_led_pwm: directed and random stimulus for rgb_led_pwm, checked
// cycle by cycle against a period-level behavioural model.
module tb_rgb_led_pwm;

  localparam int NCH     = 2;
  localparam int PWM_W   = 4;
  localparam int BLINK_W = 1;
  localparam int PMAX    = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [5:0] color;
  logic [7:0] level;
  logic [3:0] mode;
  logic [5:0] rgb_led;
  logic       period_start;

  rgb_led_pwm #(.NCH(NCH), .PWM_W(PWM_W), .BLINK_W(BLINK_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .color        (color),
    .level        (level),
    .mode         (mode),
    .rgb_led      (rgb_led),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model state: position in period, periods since reset, pending/active
  // settings and breathe ramps, all as plain integers.
  int m_cnt = 0;
  int pidx = 0;
  int out_cnt = -1;
  int cp_pidx = 0;
  int pc[2], pl[2], pm[2], ac[2], al[2], am[2], rmp[2], rup[2];
  logic [5:0] exp_led;
  logic       exp_ps;

  logic [5:0] a_col, b_col;
  logic [7:0] a_lvl, b_lvl;
  logic [3:0] a_mode, b_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic int eff_of(input int ch);
    int ph;
    ph = (pidx >> BLINK_W) & 1;
    case (am[ch])
      0: return al[ch];
      1: return (ph == 1) ? al[ch] : 0;
      2: return rmp[ch];
      default: return 0;
    endcase
  endfunction

  // Triangle wave between 0 and the level, one step per period.
  function automatic void breathe_step(input int ch);
    int lv;
    lv = al[ch];
    if (lv == 0) begin
      rmp[ch] = 0; rup[ch] = 1;
    end else if (rmp[ch] > lv) begin
      rmp[ch] = lv; rup[ch] = 0;
    end else begin
      if (rmp[ch] >= lv) rup[ch] = 0;
      if (rmp[ch] == 0)  rup[ch] = 1;
      rmp[ch] += (rup[ch] == 1) ? 1 : -1;
      if (rmp[ch] == lv) rup[ch] = 0;
      if (rmp[ch] == 0)  rup[ch] = 1;
    end
  endfunction

  task automatic tick();
    int e, old;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; pidx = 0; out_cnt = -1;
      for (int ch = 0; ch < 2; ch++) begin
        pc[ch] = 0; pl[ch] = 0; pm[ch] = 3;
        ac[ch] = 0; al[ch] = 0; am[ch] = 3;
        rmp[ch] = 0; rup[ch] = 1;
      end
      exp_led = '0;
      exp_ps  = 1'b0;
    end else begin
      out_cnt = m_cnt;
      exp_led = '0;
      for (int ch = 0; ch < 2; ch++) begin
        e = eff_of(ch);
        if ((m_cnt < e) || (e == PMAX))
          exp_led[3*ch +: 3] = 3'(ac[ch]);
      end
      exp_ps = (m_cnt == 0);
      if (load) begin
        for (int ch = 0; ch < 2; ch++) begin
          pc[ch] = int'(color[3*ch +: 3]);
          pl[ch] = int'(level[4*ch +: 4]);
          pm[ch] = int'(mode[2*ch +: 2]);
        end
      end
      if (m_cnt == PMAX) begin
        for (int ch = 0; ch < 2; ch++) begin
          old = am[ch];
          ac[ch] = pc[ch]; al[ch] = pl[ch]; am[ch] = pm[ch];
          if (am[ch] == 2) begin
            if (old != 2) begin
              rmp[ch] = 0; rup[ch] = 1;
            end else begin
              breathe_step(ch);
            end
          end
        end
        pidx++;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    #1;
    chk("rgb_led", {26'd0, rgb_led}, {26'd0, exp_led});
    chk("period_start", {31'd0, period_start}, {31'd0, exp_ps});
  endtask

  // Count lit cycles per channel over one whole period, optionally loading
  // set A and/or set B in the cycles whose counter value is la / lb.
  task automatic count_period(input int la, input int lb, output int c0, output int c1);
    int g;
    g = 0;
    while ((out_cnt != PMAX) && (g < 40)) begin
      tick();
      g++;
    end
    chk("align", {31'd0, (g < 40)}, 32'd1);
    cp_pidx = pidx;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_cnt == la) begin
        color = a_col; level = a_lvl; mode = a_mode; load = 1'b1;
      end else if (m_cnt == lb) begin
        color = b_col; level = b_lvl; mode = b_mode; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      if (rgb_led[2:0] != 3'b000) c0++;
      if (rgb_led[5:3] != 3'b000) c1++;
    end
    load = 1'b0;
  endtask

  initial begin
    int c0, c1, g, np, nl, sum;
    int bre[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    rst = 1'b1; load = 1'b0; color = '0; level = '0; mode = '1;
    a_col = '0; b_col = '0; a_lvl = '0; b_lvl = '0; a_mode = '0; b_mode = '0;
    repeat (3) tick();
    chk("reset_led", {26'd0, rgb_led}, 32'd0);
    chk("reset_ps", {31'd0, period_start}, 32'd0);
    rst = 1'b0;

    // Idle after reset: dark, one marker every 16 cycles.
    np = 0; nl = 0;
    repeat (64) begin
      tick();
      if (period_start) np++;
      if (rgb_led != 6'd0) nl++;
    end
    chk("idle_pulses", np, 4);
    chk("idle_lit", nl, 0);

    // Two SOLID channels.
    color = 6'b100_001; level = {4'd15, 4'd4}; mode = 4'b00_00; load = 1'b1;
    tick();
    load = 1'b0;
    count_period(-1, -1, c0, c1);
    chk("solid_c0", c0, 4);
    chk("solid_c1", c1, 16);

    // Mid-period load takes effect only from the next period.
    a_col = 6'b100_001; a_lvl = {4'd15, 4'd10}; a_mode = 4'b00_00;
    count_period(7, -1, c0, c1);
    chk("mid_load_cur", c0, 4);
    count_period(-1, -1, c0, c1);
    chk("mid_load_next", c0, 10);

    // Two loads within one period: second wins.
    a_lvl = {4'd15, 4'd6};
    b_col = 6'b100_001; b_lvl = {4'd15, 4'd12}; b_mode = 4'b00_00;
    count_period(3, 9, c0, c1);
    chk("two_load_cur", c0, 10);
    count_period(-1, -1, c0, c1);
    chk("two_load_next", c0, 12);

    // BLINK on channel 0, channel 1 OFF.
    color = 6'b000_010; level = {4'd0, 4'd8}; mode = 4'b11_01; load = 1'b1;
    tick();
    load = 1'b0;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      count_period(-1, -1, c0, c1);
      chk("blink_c0", c0, (((cp_pidx >> BLINK_W) & 1) == 1) ? 8 : 0);
      chk("blink_c1", c1, 0);
      sum += c0;
    end
    chk("blink_sum", sum, 16);

    // BREATHE on channel 1 with level 3.
    color = 6'b111_000; level = {4'd3, 4'd0}; mode = 4'b10_11; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      count_period(-1, -1, c0, c1);
      chk("breathe_c1", c1, bre[i]);
    end

    // Reset in the middle of a lit period.
    color = '1; level = '1; mode = 4'b00_00; load = 1'b1;
    tick();
    load = 1'b0;
    count_period(-1, -1, c0, c1);
    chk("full_c0", c0, 16);
    chk("full_c1", c1, 16);
    g = 0;
    while ((m_cnt != 9) && (g < 40)) begin
      tick();
      g++;
    end
    chk("reach_cnt9", {31'd0, (g < 40)}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_led", {26'd0, rgb_led}, 32'd0);
    chk("rst_mid_ps", {31'd0, period_start}, 32'd0);
    tick();
    chk("rst_restart_ps", {31'd0, period_start}, 32'd1);
    nl = 0;
    repeat (48) begin
      tick();
      if (rgb_led != 6'd0) nl++;
    end
    chk("rst_modes_off", nl, 0);

    // Load coinciding with reset is dropped.
    color = '1; level = '1; mode = 4'b00_00; load = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; load = 1'b0;
    nl = 0;
    repeat (40) begin
      tick();
      if (rgb_led != 6'd0) nl++;
    end
    chk("load_with_rst", nl, 0);

    // Random loads and occasional resets.
    repeat (1500) begin
      load  = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      color = 6'($urandom);
      level = 8'($urandom);
      mode  = 4'($urandom);
      tick();
    end
    rst = 1'b0;
    load = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rgb_led_pwm.md
RGB_LED_PWM -- requirements
Module: rgb_led_pwm

Interface
REQ-001 Parameter NCH, default 2: number of RGB LED channels (1..8).
REQ-002 Parameter PWM_W, default 8: brightness resolution; one PWM period = 2^PWM_W clk cycles.
REQ-003 Parameter BLINK_W, default 6: blink half-period = 2^BLINK_W PWM periods.
REQ-004 clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 load  input  1  single-cycle strobe; captures color, level and mode for all channels.
REQ-007 color  input  3*NCH  per channel {B,G,R}; channel c uses bits [3c+2:3c].
REQ-008 level  input  PWM_W*NCH  per-channel brightness; channel c uses bits [PWM_W*c+PWM_W-1:PWM_W*c].
REQ-009 mode  input  2*NCH  per channel: 00 SOLID, 01 BLINK, 10 BREATHE, 11 OFF.
REQ-010 rgb_led  output  3*NCH  registered LED drive, active-high, same bit mapping as color.
REQ-011 period_start  output  1  registered one-cycle pulse marking the first cycle of each PWM period.

Function
REQ-012 Free-running counter cnt, PWM_W bits, SHALL increment every cycle and wrap from 2^PWM_W-1 to 0.
REQ-013 On load, inputs SHALL go into pending registers; a later load before the next wrap overwrites pending (last load wins).
REQ-014 Pending SHALL copy to active registers in the cycle cnt wraps to 0; active values never change mid-period (glitch-free).
REQ-015 Load in the cycle with cnt==2^PWM_W-1 SHALL take effect in the period starting next cycle.
REQ-016 Per channel, lit = (cnt < eff_level) OR (eff_level == 2^PWM_W-1); level 0 = always dark, all-ones = 100% on.
REQ-017 SOLID: eff_level = active level.
REQ-018 BLINK: eff_level = active level while blink phase is 1, 0 while phase is 0; blink phase is global and toggles every 2^BLINK_W periods via BLINK_W-bit period counter.
REQ-019 BREATHE: per-channel ramp register (PWM_W bits) with direction bit; eff_level = ramp; at each wrap ramp steps +1 when up, -1 when down.
REQ-020 BREATHE: ramp reaching active level sets direction down; ramp reaching 0 sets direction up; active level 0 holds ramp at 0.
REQ-021 Active level lowered below current ramp: ramp SHALL clamp to new level at that wrap and direction set down.
REQ-022 Entering BREATHE from another mode SHALL restart ramp at 0, direction up.
REQ-023 OFF: eff_level = 0; channel dark regardless of color.
REQ-024 rgb_led[3c+k] SHALL register active color bit k AND lit_c; latency exactly 1 cycle from cnt value to output.
REQ-025 period_start SHALL be 1 in the cycle after cnt==0 (aligned with first output of each period), else 0.
REQ-026 Channels SHALL be fully independent except for shared cnt and blink phase.

Reset
REQ-027 While rst=1 at a clock edge: cnt=0, blink counter=0, blink phase=0, all pending/active color=000, level=0, mode=OFF, ramps=0 direction up, rgb_led=0, period_start=0.
REQ-028 Reset mid-period SHALL abort the period; first cycle after rst release has cnt=0 and period_start follows one cycle later.
REQ-029 load asserted together with rst SHALL be ignored.

Verification (NCH=2, PWM_W=4, BLINK_W=1; period 16 cycles)
REQ-030 Reset release, no load -> rgb_led=000000 for 64 cycles; period_start pulses every 16 cycles.
REQ-031 load color0=001 level0=4 SOLID, color1=100 level1=15 SOLID -> from next period: rgb_led[2:0]=001 for 4 of 16 cycles, rgb_led[5:3]=100 all 16 cycles.
REQ-032 load mid-period (cnt=7) changing level0 4->10 -> current period keeps 4 lit cycles, next period 10 lit cycles; two loads in one period -> only the second applies.
REQ-033 Channel0 BLINK level=8 color=010 -> two periods dark, two periods 8/16 lit, repeating.
REQ-034 Channel1 BREATHE level=3 color=111 -> lit counts per period 0,1,2,3,2,1,0,1 ...
REQ-035 rst pulsed one cycle at cnt=9 with both channels lit -> rgb_led=0 next cycle, all modes OFF, cnt restarts at 0.
